// File: rtl/scc_dmem_bridge_pkg.sv
// ============================================================================
// Module      : scc_dmem_pkg
// Description : Shared types and constants for the SCC data-memory bridge.
//               State encoding, error read data, default geometry and the
//               width rule for the optional request watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scc_dmem_pkg;

   // Bridge transaction states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // Data returned to the core when a read is aborted by the watchdog.
   localparam logic [31:0] DMEM_ERR_DATA = 32'hFFFF_FFFF;

   // Default word-address width and watchdog limit.
   localparam int unsigned DMEM_ADDR_W_DEF  = 16;
   localparam int unsigned DMEM_TIMEOUT_DEF = 255;

   // Watchdog counter width: wide enough for the limit, clamped to 8..16 bits.
   function automatic int unsigned dmem_cnt_width(input int unsigned cyc);
      int unsigned w;
      w = $clog2(cyc + 1);
      if (w < 8)  w = 8;
      if (w > 16) w = 16;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/scc_dmem_bridge_if.sv
// ============================================================================
// Module      : scc_dmem_bridge_if
// Description : Word-wide req/ack data-memory bus. The bridge drives the
//               master side, the memory the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scc_dmem_bridge_if
   import scc_dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W_DEF
) ();

   logic              req;    // request, held until ack
   logic              we;     // 1 = write, 0 = read
   logic [ADDR_W-1:0] addr;   // word address
   logic [31:0]       wdata;  // write data
   logic              ack;    // one-cycle completion strobe
   logic [31:0]       rdata;  // read data, valid with ack

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output ack,
      output rdata
   );

endinterface

`default_nettype wire

// File: rtl/scc_dmem_bridge_timeout.sv
// ============================================================================
// Module      : scc_dmem_timeout
// Description : Request watchdog. Clears when a request is issued, counts
//               every cycle the request is outstanding and flags expiry in
//               the LIMIT-th outstanding cycle.
//               Only instantiated when SCC_DMEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scc_dmem_timeout #(
   parameter int unsigned LIMIT = 255,
   parameter int unsigned CNT_W = 8
) (
   input  logic clk,
   input  logic reset,     // asynchronous, active-low
   input  logic clr_i,     // request being issued this cycle
   input  logic en_i,      // request outstanding this cycle
   output logic expire_o   // this outstanding cycle is the last allowed one
);

   // Count value seen during the LIMIT-th outstanding cycle.
   localparam logic [CNT_W-1:0] c_last = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;

   assign expire_o = en_i && (cnt_q == c_last);

   // Clear on issue, advance once per outstanding cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/scc_dmem_bridge.sv
// ============================================================================
// Module      : scc_dmem_bridge
// Description : Bridge from the SCC core data port to a variable-latency
//               word-wide req/ack data memory. Stalls the core for the
//               duration of each aligned access, rejects misaligned ones
//               with a one-cycle misalign pulse.
//               Optional macro SCC_DMEM_TIMEOUT_EN adds a request watchdog
//               that aborts after TIMEOUT_CYC cycles and pulses bus_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scc_dmem_bridge
   import scc_dmem_pkg::*;
#(
   parameter int unsigned ADDR_W      = DMEM_ADDR_W_DEF,
   parameter int unsigned TIMEOUT_CYC = DMEM_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,       // asynchronous, active-low
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_out,
   input  logic              data_read,
   input  logic              data_write,
   output logic [31:0]       data_in,
   output logic              stall,
   output logic              misalign,
   output logic              bus_err,
   scc_dmem_bridge_if.master mem
);

   dmem_state_e       state_q;
   logic [31:0]       data_in_q;
   logic              misalign_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   logic w_access;
   logic w_aligned;
   logic w_issue;

   assign w_access  = data_read | data_write;
   assign w_aligned = (data_addr[1:0] == 2'b00);
   // An aligned access seen in IDLE is issued at this edge.
   assign w_issue   = (state_q == IDLE) && w_access && w_aligned;

   // The core is held from the moment an aligned access is seen until RESP.
   assign stall    = w_issue || (state_q == REQ);
   assign data_in  = data_in_q;
   assign misalign = misalign_q;

   assign mem.req   = mem_req_q;
   assign mem.we    = mem_we_q;
   assign mem.addr  = mem_addr_q;
   assign mem.wdata = mem_wdata_q;

   // Address bits above the memory word address are deliberately dropped.
   if (ADDR_W + 2 < 32) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = |data_addr[31:ADDR_W+2];
   end

`ifdef SCC_DMEM_TIMEOUT_EN
   logic bus_err_q;
   logic w_expire;

   scc_dmem_timeout #(
      .LIMIT (TIMEOUT_CYC),
      .CNT_W (dmem_cnt_width(TIMEOUT_CYC))
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (w_issue),
      .en_i     (state_q == REQ),
      .expire_o (w_expire)
   );

   assign bus_err = bus_err_q;
`else
   // Without the watchdog a request waits for its ack indefinitely.
   localparam int unsigned c_unused_timeout = TIMEOUT_CYC;
   assign bus_err = 1'b0;
`endif

   // Transaction FSM with registered memory-side and status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         data_in_q   <= '0;
         misalign_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef SCC_DMEM_TIMEOUT_EN
         bus_err_q   <= 1'b0;
`endif
      end else begin
         misalign_q <= 1'b0;
`ifdef SCC_DMEM_TIMEOUT_EN
         bus_err_q  <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               // A stray ack here belongs to nothing and is ignored.
               if (w_access) begin
                  if (w_aligned) begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= data_write;   // write wins over read
                     mem_addr_q  <= data_addr[ADDR_W+1:2];
                     mem_wdata_q <= data_out;
                     state_q     <= REQ;
                  end else begin
                     misalign_q  <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (mem.ack) begin
                  mem_req_q <= 1'b0;
                  if (!mem_we_q) begin
                     data_in_q <= mem.rdata;
                  end
                  state_q <= RESP;
               end
`ifdef SCC_DMEM_TIMEOUT_EN
               else if (w_expire) begin
                  // Ack in the expiry cycle wins; only a silent memory aborts.
                  mem_req_q <= 1'b0;
                  bus_err_q <= 1'b1;
                  if (!mem_we_q) begin
                     data_in_q <= DMEM_ERR_DATA;
                  end
                  state_q <= RESP;
               end
`endif
            end
            RESP: begin
               // Core completes here; its request is not re-sampled.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_scc_dmem_bridge.sv
// ============================================================================
// Module      : tb_scc_dmem_bridge
// Description : Self-checking bench for scc_dmem_bridge. Directed vector
//               table for single accesses (issued back to back) plus
//               hand-written reset-mid-request and watchdog sequences.
//               Watchdog sequence runs only with SCC_DMEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scc_dmem_bridge;

`ifdef SCC_DMEM_TIMEOUT_EN
   localparam int unsigned c_tmo = 4;
`else
   localparam int unsigned c_tmo = 255;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_addr;
   logic [31:0] data_out;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_in;
   logic        stall;
   logic        misalign;
   logic        bus_err;

   scc_dmem_bridge_if #(.ADDR_W(16)) mem_bus ();

   scc_dmem_bridge #(
      .ADDR_W      (16),
      .TIMEOUT_CYC (c_tmo)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_addr  (data_addr),
      .data_out   (data_out),
      .data_read  (data_read),
      .data_write (data_write),
      .data_in    (data_in),
      .stall      (stall),
      .misalign   (misalign),
      .bus_err    (bus_err),
      .mem        (mem_bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Count mem_req rising edges to prove each access is issued once.
   int   n_rise   = 0;
   int   exp_rise = 0;
   logic req_prev = 1'b0;
   always @(negedge clk) begin
      if (mem_bus.req === 1'b1 && req_prev !== 1'b1) n_rise++;
      req_prev = mem_bus.req;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Move to just after the next rising edge, where inputs are driven.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic core_idle();
      data_addr  = 32'h0;
      data_out   = 32'h0;
      data_read  = 1'b0;
      data_write = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rd;
      logic        wr;
      int          ack_dly;   // cycle index of ack (>= 1)
      logic [31:0] rdata;
      logic        exp_mis;
      logic        exp_we;
      logic [15:0] exp_maddr;
      logic [31:0] exp_din;
   } vec_t;

   vec_t vecs[7];

   // Present one access at the current cycle (cycle 0) and follow it through.
   // Returns at the start of the cycle after the access completes, with the
   // request still driven so the next vector can follow immediately.
   task automatic run_vec(input int idx, input vec_t v);
      string p;
      p = $sformatf("v%0d", idx);
      data_addr  = v.addr;
      data_out   = v.wdata;
      data_read  = v.rd;
      data_write = v.wr;
      mem_bus.ack   = 1'b0;
      mem_bus.rdata = 32'hBAD0_0000;
      @(negedge clk);
      chk({p, " misalign_c0"}, misalign, 1'b0);
      if (v.exp_mis) begin
         chk({p, " stall_c0"}, stall, 1'b0);
         step();
         core_idle();
         @(negedge clk);
         chk({p, " misalign_c1"}, misalign, 1'b1);
         chk({p, " req_c1"}, mem_bus.req, 1'b0);
         chk({p, " stall_c1"}, stall, 1'b0);
         chk({p, " data_in"}, data_in, v.exp_din);
         chk({p, " req_count"}, n_rise, exp_rise);
         step();
      end else begin
         exp_rise++;
         chk({p, " stall_c0"}, stall, 1'b1);
         for (int c = 1; c <= v.ack_dly; c++) begin
            step();
            if (c == v.ack_dly) begin
               mem_bus.ack   = 1'b1;
               mem_bus.rdata = v.rdata;
            end else begin
               mem_bus.rdata = 32'hBAD0_0000 + c;
            end
            @(negedge clk);
            chk({p, $sformatf(" req_c%0d", c)}, mem_bus.req, 1'b1);
            chk({p, $sformatf(" stall_c%0d", c)}, stall, 1'b1);
            if (c == 1) begin
               chk({p, " mem_we"}, mem_bus.we, v.exp_we);
               chk({p, " mem_addr"}, mem_bus.addr, v.exp_maddr);
               if (v.exp_we) chk({p, " mem_wdata"}, mem_bus.wdata, v.wdata);
            end
         end
         step();
         mem_bus.ack   = 1'b0;
         mem_bus.rdata = 32'hBAD0_1111;
         @(negedge clk);
         chk({p, " stall_resp"}, stall, 1'b0);
         chk({p, " req_resp"}, mem_bus.req, 1'b0);
         chk({p, " bus_err"}, bus_err, 1'b0);
         chk({p, " data_in"}, data_in, v.exp_din);
         chk({p, " req_count"}, n_rise, exp_rise);
         step();
      end
   endtask

   initial begin
      //           addr           wdata          rd wr dly rdata          mis we maddr     din
      vecs[0] = '{32'h0000_0010, 32'h0000_0000, 1, 0, 3, 32'hCAFE_0001, 0, 0, 16'h0004, 32'hCAFE_0001};
      vecs[1] = '{32'h0000_0020, 32'h1234_5678, 0, 1, 1, 32'hDEAD_BEEF, 0, 1, 16'h0008, 32'hCAFE_0001};
      vecs[2] = '{32'h0000_0000, 32'hA5A5_5A5A, 1, 1, 2, 32'h5555_AAAA, 0, 1, 16'h0000, 32'hCAFE_0001};
      vecs[3] = '{32'h0000_0006, 32'h0000_0000, 1, 0, 1, 32'h0000_0000, 1, 0, 16'h0000, 32'hCAFE_0001};
      vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 1, 32'h0BAD_F00D, 0, 0, 16'hFFFF, 32'h0BAD_F00D};
      vecs[5] = '{32'h0000_0003, 32'h7777_0000, 0, 1, 1, 32'h0000_0000, 1, 1, 16'h0000, 32'h0BAD_F00D};
      vecs[6] = '{32'h0004_0008, 32'h0000_0000, 1, 0, 5, 32'h1357_9BDF, 0, 0, 16'h0002, 32'h1357_9BDF};

      // Reset state.
      reset = 1'b0;
      core_idle();
      mem_bus.ack   = 1'b0;
      mem_bus.rdata = 32'h0;
      @(negedge clk);
      chk("rst data_in", data_in, 32'h0);
      chk("rst stall", stall, 1'b0);
      chk("rst misalign", misalign, 1'b0);
      chk("rst bus_err", bus_err, 1'b0);
      chk("rst mem_req", mem_bus.req, 1'b0);
      chk("rst mem_we", mem_bus.we, 1'b0);
      chk("rst mem_addr", mem_bus.addr, 16'h0);
      chk("rst mem_wdata", mem_bus.wdata, 32'h0);
      step();
      reset = 1'b1;
      step();

      // Table: accesses issued back to back.
      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
      core_idle();
      step();

`ifdef SCC_DMEM_TIMEOUT_EN
      // Read never acked: four REQ cycles, then abort.
      data_addr = 32'h0000_0080;
      data_read = 1'b1;
      exp_rise++;
      @(negedge clk);
      chk("tmo stall_c0", stall, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         step();
         @(negedge clk);
         chk($sformatf("tmo req_c%0d", c), mem_bus.req, 1'b1);
         chk($sformatf("tmo bus_err_c%0d", c), bus_err, 1'b0);
      end
      step();
      @(negedge clk);
      chk("tmo req_c5", mem_bus.req, 1'b0);
      chk("tmo stall_c5", stall, 1'b0);
      chk("tmo bus_err_c5", bus_err, 1'b1);
      chk("tmo data_in", data_in, 32'hFFFF_FFFF);
      step();
      core_idle();
      mem_bus.ack   = 1'b1;
      mem_bus.rdata = 32'h1111_1111;
      @(negedge clk);
      chk("tmo bus_err_c6", bus_err, 1'b0);
      chk("tmo req_c6", mem_bus.req, 1'b0);
      step();
      mem_bus.ack = 1'b0;
      @(negedge clk);
      chk("tmo late_ack data_in", data_in, 32'hFFFF_FFFF);
      chk("tmo req_count", n_rise, exp_rise);
      step();
`endif

      // Reset in the middle of an outstanding read.
      data_addr = 32'h0000_0040;
      data_read = 1'b1;
      exp_rise++;
      @(negedge clk);
      chk("rreq stall_c0", stall, 1'b1);
      step();
      @(negedge clk);
      chk("rreq req_c1", mem_bus.req, 1'b1);
      chk("rreq addr_c1", mem_bus.addr, 16'h0010);
      step();
      #2;
      reset = 1'b0;
      core_idle();
      #1;
      chk("rreq req_async", mem_bus.req, 1'b0);
      chk("rreq stall_async", stall, 1'b0);
      chk("rreq data_in_async", data_in, 32'h0);
      step();
      reset = 1'b1;
      step();
      mem_bus.ack   = 1'b1;
      mem_bus.rdata = 32'h7777_7777;
      @(negedge clk);
      chk("rreq req_lateack", mem_bus.req, 1'b0);
      chk("rreq stall_lateack", stall, 1'b0);
      step();
      mem_bus.ack = 1'b0;
      @(negedge clk);
      chk("rreq data_in_after", data_in, 32'h0);
      chk("rreq req_after", mem_bus.req, 1'b0);
      chk("rreq req_count", n_rise, exp_rise);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
